// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_pkg
//  Description : Shared state encoding and parity helper for the serial
//                receiver frame controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    // Frame controller state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_DATA = 2'd1;
    localparam logic [1:0] c_ST_PAR  = 2'd2;
    localparam logic [1:0] c_ST_STOP = 2'd3;

    // Reduction XOR over a zero-extended word. Zero padding does not change
    // the result, so any frame width up to 32 bits can use it.
    function automatic logic f_xor_reduce(input logic [31:0] i_d);
        return ^i_d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_shift_reg
//  Description : Serial-in/parallel-out shift register. Shifts left with the
//                new bit entering the LSB, so the first bit received ends up
//                in the MSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             sdi,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_sr;

    // Shift one bit in on every enabled cycle; cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr <= '0;
        end else if (shift_en) begin
            r_sr <= {r_sr[WIDTH-2:0], sdi};
        end
    end

    assign Q = r_sr;

endmodule
`default_nettype wire

// File: rtl/sipo_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_rx_ctrl
//  Description : Serial receiver frame controller. Detects a start bit,
//                shifts WIDTH data bits MSB-first, optionally checks parity,
//                checks the stop bit and presents good words on a registered
//                valid/ready parallel output.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_rx_ctrl
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sdi,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned    c_CW         = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(WIDTH - 1);
    localparam logic           c_PAR_EN     = (PARITY_EN != 0);
    localparam logic           c_PAR_TARGET = (PARITY_ODD != 0);

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic             r_par;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic [WIDTH-1:0] w_sr;
    logic             w_shift;
    logic             w_stop_eval;
    logic             w_par_ok;
    logic             w_frame_ok;
    logic             w_good;
    logic             w_bad;
    logic             w_load;

    assign w_shift     = en && (r_state == c_ST_DATA);
    assign w_stop_eval = en && (r_state == c_ST_STOP);

    sipo_shift_reg #(
        .WIDTH    (WIDTH)
    ) u_shift_reg (
        .clk      (clk),
        .reset    (reset),
        .shift_en (w_shift),
        .sdi      (sdi),
        .Q        (w_sr)
    );

    // Data bits XOR parity bit must match the configured sense
    assign w_par_ok   = ((f_xor_reduce(32'(w_sr)) ^ r_par) == c_PAR_TARGET);
    assign w_frame_ok = sdi && (w_par_ok || !c_PAR_EN);
    assign w_good     = w_stop_eval && w_frame_ok;
    assign w_bad      = w_stop_eval && !w_frame_ok;
    // A good word is taken if the output is free or is being consumed now
    assign w_load     = w_good && (!r_q_valid || q_ready);

    // Frame sequencing: start detect, data count, parity capture, stop check
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_par   <= 1'b0;
        end else if (en) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!sdi) begin
                        r_state <= c_ST_DATA;
                        r_cnt   <= '0;
                    end
                end
                c_ST_DATA: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_PAR_EN ? c_ST_PAR : c_ST_STOP;
                    end
                end
                c_ST_PAR: begin
                    r_par   <= sdi;
                    r_state <= c_ST_STOP;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Output word, handshake and single-cycle status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q         <= '0;
            r_q_valid   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            r_overrun   <= w_good && !w_load;
            if (w_load) begin
                r_q       <= w_sr;
                r_q_valid <= 1'b1;
            end else if (r_q_valid && q_ready) begin
                r_q_valid <= 1'b0;
            end
        end
    end

    assign q         = r_q;
    assign q_valid   = r_q_valid;
    assign busy      = (r_state != c_ST_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
